// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, branch redirect, IF/ID pipeline latch.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        br_use_reg,
    input  logic [63:0] br_target,
    input  logic [63:0] br_reg,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    output logic [63:0] id_pc_plus4,
    output logic        id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    logic [63:0] pc_q, pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [63:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;
    logic [63:0] raw_target_s;
    logic [63:0] redirect_s;
    logic [63:0] pc_plus4_s;
    logic        fetch_load_s;

    // Next-state selection: a redirect wins over a stall and bubbles IF/ID
    always_comb begin
        raw_target_s  = br_use_reg ? br_reg : br_target;
        redirect_s    = {raw_target_s[63:2], 2'b00};
        pc_plus4_s    = pc_q + 64'd4;
        pc_d          = pc_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        misalign_d    = misalign_q;
        fetch_load_s  = 1'b0;
        if (br_taken) begin
            pc_d       = redirect_s;
            id_inst_d  = 32'd0;
            id_valid_d = 1'b0;
            misalign_d = misalign_q | (raw_target_s[1:0] != 2'b00);
        end else if (!stall) begin
            pc_d          = pc_plus4_s;
            id_inst_d     = imem_data;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4_s;
            id_valid_d    = 1'b1;
            fetch_load_s  = 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC, IF/ID latch and sticky misalignment flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= 64'd0;
            id_inst_q     <= 32'd0;
            id_pc_q       <= 64'd0;
            id_pc_plus4_q <= 64'd0;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_addr    = pc_q;
    assign id_inst      = id_inst_q;
    assign id_pc        = id_pc_q;
    assign id_pc_plus4  = id_pc_plus4_q;
    assign id_valid     = id_valid_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Counter increments; both wrap naturally at 32 bits
    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (fetch_load_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
        if (br_taken) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`else
    assign fetch_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with a cycle-level reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic        br_use_reg;
    logic [63:0] br_target;
    logic [63:0] br_reg;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic [63:0] id_pc_plus4;
    logic        id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    logic [63:0] m_pc, m_id_pc, m_id_pc4;
    logic [31:0] m_inst, m_fetch, m_flush;
    logic        m_valid, m_mis;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_use_reg(br_use_reg), .br_target(br_target), .br_reg(br_reg),
        .imem_addr(imem_addr), .imem_data(imem_data), .id_inst(id_inst),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        if (a == 64'd0) return 32'h8B02_0020;
        if (a == 64'd4) return 32'h9100_0421;
        return a[33:2] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_data = mem_fn(imem_addr);

    function automatic logic [31:0] exp_fetch();
`ifdef FETCH_PERF_CNT_EN
        return m_fetch;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush();
`ifdef FETCH_PERF_CNT_EN
        return m_flush;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 64'd0; m_id_pc = 64'd0; m_id_pc4 = 64'd0; m_inst = 32'd0;
        m_valid = 1'b0; m_mis = 1'b0; m_fetch = 32'd0; m_flush = 32'd0;
    endtask

    // drive one cycle's inputs (called at negedge), advance model, settle at next negedge
    task automatic step(input logic s, input logic bt, input logic ur,
                        input logic [63:0] tgt, input logic [63:0] rg);
        logic [63:0] raw;
        stall = s; br_taken = bt; br_use_reg = ur; br_target = tgt; br_reg = rg;
        raw = ur ? rg : tgt;
        if (bt) begin
            m_flush = m_flush + 32'd1;
            if (raw % 4 != 0) m_mis = 1'b1;
            m_pc = raw - (raw % 4);
            m_inst = 32'd0;
            m_valid = 1'b0;
        end else if (!s) begin
            m_inst = mem_fn(m_pc);
            m_id_pc = m_pc;
            m_id_pc4 = m_pc + 64'd4;
            m_valid = 1'b1;
            m_fetch = m_fetch + 32'd1;
            m_pc = m_pc + 64'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_use_reg = 1'b0;
        br_target = 64'd0; br_reg = 64'd0;
        model_reset();
        repeat (2) @(negedge clk);
        n_total++; if (imem_addr !== 64'd0) $display("FAIL rst_addr got %h exp 0", imem_addr); else n_pass++;
        n_total++; if (id_inst !== 32'd0) $display("FAIL rst_inst got %h exp 0", id_inst); else n_pass++;
        n_total++; if (id_pc !== 64'd0 || id_pc_plus4 !== 64'd0) $display("FAIL rst_pc got %h/%h exp 0", id_pc, id_pc_plus4); else n_pass++;
        n_total++; if (id_valid !== 1'b0 || misalign_err !== 1'b0) $display("FAIL rst_flags got %b%b exp 00", id_valid, misalign_err); else n_pass++;
        n_total++; if (fetch_count !== 32'd0 || flush_count !== 32'd0) $display("FAIL rst_cnt got %h/%h exp 0", fetch_count, flush_count); else n_pass++;
    endtask

    task automatic test_first_fetch();
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        n_total++; if (id_pc !== 64'd0) $display("FAIL ff_pc got %h exp 0", id_pc); else n_pass++;
        n_total++; if (id_inst !== 32'h8B02_0020) $display("FAIL ff_inst got %h exp 8b020020", id_inst); else n_pass++;
        n_total++; if (id_valid !== 1'b1) $display("FAIL ff_valid got %b exp 1", id_valid); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        n_total++; if (id_pc !== 64'd4 || id_pc_plus4 !== 64'd8) $display("FAIL ff2_pc got %h/%h exp 4/8", id_pc, id_pc_plus4); else n_pass++;
        n_total++; if (id_inst !== 32'h9100_0421) $display("FAIL ff2_inst got %h exp 91000421", id_inst); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] s_inst, s_fc;
        logic [63:0] s_pc;
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        n_total++; if (imem_addr !== 64'h10) $display("FAIL st_pre got %h exp 10", imem_addr); else n_pass++;
        s_inst = m_inst; s_pc = m_id_pc; s_fc = exp_fetch();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
            n_total++; if (imem_addr !== 64'h10) $display("FAIL st_addr got %h exp 10", imem_addr); else n_pass++;
            n_total++; if (id_inst !== s_inst || id_pc !== s_pc || id_valid !== 1'b1) $display("FAIL st_ifid got %h/%h exp %h/%h", id_inst, id_pc, s_inst, s_pc); else n_pass++;
            n_total++; if (fetch_count !== s_fc) $display("FAIL st_fcnt got %0d exp %0d", fetch_count, s_fc); else n_pass++;
        end
    endtask

    task automatic test_branch_stall();
        logic [63:0] s_pc, s_pc4;
        s_pc = m_id_pc; s_pc4 = m_id_pc4;
        step(1'b1, 1'b1, 1'b0, 64'h40, 64'h999);
        n_total++; if (imem_addr !== 64'h40) $display("FAIL bs_addr got %h exp 40", imem_addr); else n_pass++;
        n_total++; if (id_valid !== 1'b0 || id_inst !== 32'd0) $display("FAIL bs_bubble got %b/%h exp 0/0", id_valid, id_inst); else n_pass++;
        n_total++; if (id_pc !== s_pc || id_pc_plus4 !== s_pc4) $display("FAIL bs_hold got %h/%h exp %h/%h", id_pc, id_pc_plus4, s_pc, s_pc4); else n_pass++;
        n_total++; if (flush_count !== exp_flush()) $display("FAIL bs_flush got %0d exp %0d", flush_count, exp_flush()); else n_pass++;
        n_total++; if (misalign_err !== 1'b0) $display("FAIL bs_mis got %b exp 0", misalign_err); else n_pass++;
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        n_total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wr_addr got %h exp fffffffffffffffc", imem_addr); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        n_total++; if (imem_addr !== 64'd0) $display("FAIL wr_next got %h exp 0", imem_addr); else n_pass++;
        n_total++; if (id_pc_plus4 !== 64'd0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wr_ifid got %h/%h exp fffffffffffffffc/0", id_pc, id_pc_plus4); else n_pass++;
    endtask

    task automatic test_random();
        logic s, bt, ur;
        logic [63:0] tgt, rg;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(3) == 0);
            bt = ($urandom_range(4) == 0);
            ur = $urandom_range(1);
            tgt = {$urandom, $urandom};
            rg = {$urandom, $urandom};
            if ($urandom_range(3) != 0) begin tgt[1:0] = 2'b00; rg[1:0] = 2'b00; end
            step(s, bt, ur, tgt, rg);
            n_total++; if (imem_addr !== m_pc) $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, m_pc); else n_pass++;
            n_total++; if (id_inst !== m_inst || id_valid !== m_valid) $display("FAIL rnd_inst cyc %0d got %h/%b exp %h/%b", i, id_inst, id_valid, m_inst, m_valid); else n_pass++;
            n_total++; if (id_pc !== m_id_pc || id_pc_plus4 !== m_id_pc4) $display("FAIL rnd_pc cyc %0d got %h/%h exp %h/%h", i, id_pc, id_pc_plus4, m_id_pc, m_id_pc4); else n_pass++;
            n_total++; if (misalign_err !== m_mis) $display("FAIL rnd_mis cyc %0d got %b exp %b", i, misalign_err, m_mis); else n_pass++;
            n_total++; if (fetch_count !== exp_fetch() || flush_count !== exp_flush()) $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", i, fetch_count, flush_count, exp_fetch(), exp_flush()); else n_pass++;
        end
    endtask

    task automatic test_misalign();
        // fresh reset so the sticky flag starts clear
        reset = 1'b1; br_taken = 1'b0; stall = 1'b0; model_reset();
        @(negedge clk); reset = 1'b0;
        step(1'b0, 1'b1, 1'b1, 64'h200, 64'h103);
        n_total++; if (imem_addr !== 64'h100) $display("FAIL ma_addr got %h exp 100", imem_addr); else n_pass++;
        n_total++; if (misalign_err !== 1'b1) $display("FAIL ma_set got %b exp 1", misalign_err); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 64'h300, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        n_total++; if (misalign_err !== 1'b1 || imem_addr !== 64'h304) $display("FAIL ma_sticky got %b/%h exp 1/304", misalign_err, imem_addr); else n_pass++;
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        stall = 1'b1; br_taken = 1'b1; br_use_reg = 1'b0; br_target = 64'h81;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_total++; if (imem_addr !== 64'd0 || id_pc !== 64'd0 || id_pc_plus4 !== 64'd0) $display("FAIL ar_pc got %h/%h/%h exp 0", imem_addr, id_pc, id_pc_plus4); else n_pass++;
        n_total++; if (id_inst !== 32'd0 || id_valid !== 1'b0 || misalign_err !== 1'b0) $display("FAIL ar_ifid got %h/%b/%b exp 0", id_inst, id_valid, misalign_err); else n_pass++;
        n_total++; if (fetch_count !== 32'd0 || flush_count !== 32'd0) $display("FAIL ar_cnt got %h/%h exp 0", fetch_count, flush_count); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++; if (imem_addr !== 64'd0 || misalign_err !== 1'b0) $display("FAIL ar_hold got %h/%b exp 0/0", imem_addr, misalign_err); else n_pass++;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        n_total++; if (id_pc !== 64'd0 || id_valid !== 1'b1 || imem_addr !== 64'd4) $display("FAIL ar_first got %h/%b/%h exp 0/1/4", id_pc, id_valid, imem_addr); else n_pass++;
        n_total++; if (fetch_count !== exp_fetch() || flush_count !== exp_flush()) $display("FAIL ar_cnt2 got %0d/%0d exp %0d/%0d", fetch_count, flush_count, exp_fetch(), exp_flush()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_random();
        test_misalign();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port stall, input, 1: hazard hold from the decode/forwarding logic.
REQ-004 SHALL have port br_taken, input, 1: redirect request from branch resolution.
REQ-005 SHALL have port br_use_reg, input, 1: redirect target comes from br_reg (BR) instead of br_target.
REQ-006 SHALL have port br_target, input, 64: PC-relative branch target.
REQ-007 SHALL have port br_reg, input, 64: register-sourced target (Db).
REQ-008 SHALL have port imem_addr, output, 64: instruction memory address, equal to current PC, combinational.
REQ-009 SHALL have port imem_data, input, 32: instruction word returned the same cycle.
REQ-010 SHALL have port id_inst, output, 32: IF/ID latched instruction.
REQ-011 SHALL have port id_pc, output, 64: IF/ID latched PC of id_inst.
REQ-012 SHALL have port id_pc_plus4, output, 64: IF/ID latched PC+4.
REQ-013 SHALL have port id_valid, output, 1: IF/ID holds a real instruction, not a bubble.
REQ-014 SHALL have port misalign_err, output, 1: sticky flag for a redirect target with bits[1:0] != 0.
REQ-015 SHALL have port fetch_count, output, 32: performance counter (see Configuration).
REQ-016 SHALL have port flush_count, output, 32: performance counter (see Configuration).

Function
REQ-017 SHALL compute the redirect target as (br_use_reg ? br_reg : br_target) with bits[1:0] forced to 0.
REQ-018 SHALL compute next PC as the redirect target when br_taken=1, else PC+4, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0).
REQ-019 SHALL, when stall=0 and br_taken=0: load PC with next PC and load IF/ID with {imem_data, PC, PC+4, valid=1}.
REQ-020 SHALL, when stall=1 and br_taken=0: hold PC and all IF/ID registers unchanged.
REQ-021 SHALL, when br_taken=1 (regardless of stall): load PC with the redirect target, load id_inst=0, id_valid=0, and hold id_pc and id_pc_plus4.
REQ-022 SHALL set misalign_err on any br_taken=1 edge whose selected raw target has bits[1:0] != 0; cleared only by reset.
REQ-023 SHALL produce id_inst for address A exactly one cycle after imem_addr=A with no stall and no redirect.

Reset
REQ-024 SHALL asynchronously set PC=0, id_inst=0, id_pc=0, id_pc_plus4=0, id_valid=0, misalign_err=0, fetch_count=0, flush_count=0 while reset=1.
REQ-025 SHALL drive imem_addr=0 during reset and SHALL fetch address 0 on the first rising edge after deassertion.
REQ-026 SHALL discard any in-flight redirect or stall when reset asserts mid-operation; no partial update survives.

Configuration
REQ-027 SHALL compile the performance counters only when the macro FETCH_PERF_CNT_EN is defined.
REQ-028 SHALL, with FETCH_PERF_CNT_EN defined: increment fetch_count on each edge on which IF/ID loads valid=1, and increment flush_count on each edge with br_taken=1; both wrap from 0xFFFF_FFFF to 0.
REQ-029 SHALL, without FETCH_PERF_CNT_EN: keep both ports present and drive them to constant 0 with no counter flops.

Verification
REQ-030 SHALL pass this scenario: release reset, imem returns 0x8B020020 at address 0 and 0x91000421 at address 4 -> cycle 1 id_pc=0, id_inst=0x8B020020, id_valid=1; cycle 2 id_pc=4, id_pc_plus4=8.
REQ-031 SHALL pass this scenario: stall=1 for 3 cycles with PC=0x10 -> imem_addr stays 0x10; IF/ID is unchanged; fetch_count does not increment.
REQ-032 SHALL pass this scenario: br_taken=1, br_use_reg=0, br_target=0x40, at the same time as stall=1 -> next imem_addr=0x40; id_valid=0; id_inst=0; flush_count +1.
REQ-033 SHALL pass this scenario: br_taken=1, br_use_reg=1, br_reg=0x103 -> imem_addr=0x100; misalign_err=1 and it remains set after later aligned branches.
REQ-034 SHALL pass this scenario: PC forced to 0xFFFF_FFFF_FFFF_FFFC via redirect, then no stall -> next imem_addr=0; id_pc_plus4=0.
REQ-035 SHALL pass this scenario: assert reset between clock edges mid-stream -> all outputs read 0 immediately; first fetch after release is address 0; with FETCH_PERF_CNT_EN undefined, both counters read 0 throughout.
